fir_filter: RTL and testbench

Four-tap pipelined direct-form FIR low-pass filter. It sits directly downstream of the signal generator and consumes its NB_DATA-bit signed sample stream, one sample per qualified clock. Coefficients are runtime-writable and reset to a unity-DC-gain low-pass set. The output is rounded, saturated and flagged, and feeds the lab's timing-analysis top level.

---
 rtl/fir_filter.sv | 132 +++++++++++++
 tb/tb_fir_filter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// Four-tap pipelined direct-form FIR low-pass filter.
// Taps -> products -> pair sums -> round/saturate, with a valid pipe
// running alongside so each result is tagged with its source sample.
//
// Stream protocol: valid-only, no backpressure. i_valid marks i_data as a
// new sample on that rising edge; o_valid marks o_data/o_sat as a result
// on that cycle and the consumer must take every o_valid cycle. o_data and
// o_sat carry no meaning while o_valid is low.
module fir_filter #(
  parameter int NB_DATA  = 8,
  parameter int NB_COEFF = 8,
  parameter int NB_OUT   = 8,
  parameter int SHIFT    = 7,
  parameter logic signed [NB_COEFF-1:0] COEF0 = 8'sd16,
  parameter logic signed [NB_COEFF-1:0] COEF1 = 8'sd48,
  parameter logic signed [NB_COEFF-1:0] COEF2 = 8'sd48,
  parameter logic signed [NB_COEFF-1:0] COEF3 = 8'sd16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_data,
  input  logic                       i_coef_we,
  input  logic [1:0]                 i_coef_addr,
  input  logic signed [NB_COEFF-1:0] i_coef_data,
  output logic                       o_valid,
  output logic signed [NB_OUT-1:0]   o_data,
  output logic                       o_sat
);

  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_SUM  = NB_PROD + 1;
  localparam int NB_ACC  = NB_PROD + 2;

  // Half an output LSB, added before the shift so rounding is half-up.
  localparam logic signed [NB_ACC-1:0] RND     = NB_ACC'(2 ** (SHIFT - 1));
  localparam logic signed [NB_ACC-1:0] MAX_POS = NB_ACC'(2 ** (NB_OUT - 1) - 1);
  localparam logic signed [NB_ACC-1:0] MIN_NEG = NB_ACC'(-(2 ** (NB_OUT - 1)));
  localparam logic signed [NB_OUT-1:0] OUT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_OUT-1:0] OUT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

  logic signed [NB_DATA-1:0]  x_q [4];
  logic signed [NB_DATA-1:0]  x_d [4];
  logic signed [NB_COEFF-1:0] c_q [4];
  logic signed [NB_COEFF-1:0] c_d [4];
  logic signed [NB_PROD-1:0]  p_q [4];
  logic signed [NB_PROD-1:0]  p_d [4];
  logic signed [NB_SUM-1:0]   s01_q, s01_d;
  logic signed [NB_SUM-1:0]   s23_q, s23_d;
  logic [3:0]                 vld_q, vld_d;
  logic signed [NB_OUT-1:0]   data_q, data_d;
  logic                       sat_q, sat_d;
  logic signed [NB_ACC-1:0]   acc, acc_rnd, r;

  // Tap line advances only on accepted samples; coefficient file takes writes.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      x_d[k] = x_q[k];
      c_d[k] = c_q[k];
    end
    if (i_valid) begin
      x_d[3] = x_q[2];
      x_d[2] = x_q[1];
      x_d[1] = x_q[0];
      x_d[0] = i_data;
    end
    if (i_coef_we) begin
      c_d[i_coef_addr] = i_coef_data;
    end
    vld_d = {vld_q[2:0], i_valid};
  end

  // Products and pair sums re-evaluate every edge; bubbles are masked by the valid pipe.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      p_d[k] = NB_PROD'(x_q[k]) * NB_PROD'(c_q[k]);
    end
    s01_d = NB_SUM'(p_q[0]) + NB_SUM'(p_q[1]);
    s23_d = NB_SUM'(p_q[2]) + NB_SUM'(p_q[3]);
  end

  // Final add, half-up rounding, then clip to the output rails.
  always_comb begin
    acc     = NB_ACC'(s01_q) + NB_ACC'(s23_q);
    acc_rnd = acc + RND;
    r       = acc_rnd >>> SHIFT;
    data_d  = r[NB_OUT-1:0];
    sat_d   = 1'b0;
    if (r > MAX_POS) begin
      data_d = OUT_MAX;
      sat_d  = 1'b1;
    end else if (r < MIN_NEG) begin
      data_d = OUT_MIN;
      sat_d  = 1'b1;
    end
  end

  // All pipeline state; reset clears data and restores default coefficients.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < 4; k++) begin
        x_q[k] <= '0;
        p_q[k] <= '0;
      end
      c_q[0] <= COEF0;
      c_q[1] <= COEF1;
      c_q[2] <= COEF2;
      c_q[3] <= COEF3;
      s01_q  <= '0;
      s23_q  <= '0;
      vld_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        x_q[k] <= x_d[k];
        c_q[k] <= c_d[k];
        p_q[k] <= p_d[k];
      end
      s01_q  <= s01_d;
      s23_q  <= s23_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign o_valid = vld_q[3];
  assign o_data  = data_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_filter.sv
// Testbench for fir_filter: directed test-plan sequences plus random traffic,
// checked every cycle against a sample-history convolution model.
module tb_fir_filter;

  logic              i_clock;
  logic              i_reset;
  logic              i_valid;
  logic signed [7:0] i_data;
  logic              i_coef_we;
  logic [1:0]        i_coef_addr;
  logic signed [7:0] i_coef_data;
  logic              o_valid;
  logic signed [7:0] o_data;
  logic              o_sat;

  fir_filter dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_sat       (o_sat)
  );

  // ---------------- clock ----------------
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // ---------------- counters and scoreboard ----------------
  int total = 0;
  int bad   = 0;

  // Entry per clock edge: {valid, sat, data[7:0]}; front is three edges old.
  logic [9:0] exp_q[$];
  // Model's valid outputs, in order, for pinning against literals.
  int mlog_d[$];
  int mlog_s[$];

  // Behavioural model: last four accepted samples (newest first) and coefs.
  int hist[4];
  int mc[4];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_out();
    int acc;
    int r;
    logic [9:0] e;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += hist[k] * mc[k];
    r = (acc + 64) >>> 7;
    if (r > 127) e = {1'b1, 1'b1, 8'h7f};
    else if (r < -128) e = {1'b1, 1'b1, 8'h80};
    else e = {1'b1, 1'b0, r[7:0]};
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) hist[k] = 0;
    mc[0] = 16; mc[1] = 48; mc[2] = 48; mc[3] = 16;
    exp_q.delete();
    // Valid pipe is empty for the first three edges after reset.
    repeat (3) exp_q.push_back(10'd0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic signed [7:0] d,
                      input logic we, input logic [1:0] a,
                      input logic signed [7:0] cd);
    logic [9:0] e;
    i_valid     = v;
    i_data      = d;
    i_coef_we   = we;
    i_coef_addr = a;
    i_coef_data = cd;
    @(posedge i_clock);
    #1;
    // Write lands on this edge; a sample accepted on this edge already sees it.
    if (we) mc[a] = cd;
    e = 10'd0;
    if (v) begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = d;
      e = model_out();
      mlog_d.push_back(int'($signed(e[7:0])));
      mlog_s.push_back(int'(e[8]));
    end
    exp_q.push_back(e);
  endtask

  task automatic feed(input int n, input logic signed [7:0] d);
    repeat (n) step(1'b1, d, 1'b0, 2'd0, 8'sd0);
  endtask

  task automatic clear_log();
    mlog_d.delete();
    mlog_s.delete();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string name);
    #2;
    i_reset = 1'b1;
    #1;
    check({name, "_valid"}, int'(o_valid), 0);
    check({name, "_data"},  int'(o_data), 0);
    check({name, "_sat"},   int'(o_sat), 0);
    model_reset();
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input int d, input int s);
    if (idx < mlog_d.size()) begin
      check({name, "_d"}, mlog_d[idx], d);
      check({name, "_s"}, mlog_s[idx], s);
    end else begin
      check({name, "_missing"}, mlog_d.size(), idx + 1);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge i_clock) begin : cmp
    logic [9:0] e;
    if (!i_reset && exp_q.size() > 3) begin
      e = exp_q.pop_front();
      if (e[9]) check("out", int'({o_valid, o_sat, o_data}), int'(e));
      else      check("out_bubble", int'(o_valid), 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    i_reset     = 1'b0;
    i_valid     = 1'b0;
    i_data      = '0;
    i_coef_we   = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    model_reset();
    #1;
    i_reset = 1'b1;
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_data",  int'(o_data), 0);
    check("rst_sat",   int'(o_sat), 0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    // Impulse with default coefficients.
    clear_log();
    feed(1, 8'sd127);
    feed(7, 8'sd0);
    check_log("imp0", 0, 16, 0);
    check_log("imp1", 1, 48, 0);
    check_log("imp2", 2, 48, 0);
    check_log("imp3", 3, 16, 0);
    check_log("imp4", 4, 0, 0);

    // DC step of 64.
    clear_log();
    feed(8, 8'sd64);
    check_log("dc0", 0, 8, 0);
    check_log("dc1", 1, 32, 0);
    check_log("dc2", 2, 56, 0);
    check_log("dc3", 3, 64, 0);
    check_log("dc7", 7, 64, 0);

    // Negative input, rounding toward +inf.
    feed(4, 8'sd0);
    clear_log();
    feed(6, -8'sd1);
    check_log("neg0", 0, 0, 0);
    check_log("neg2", 2, -1, 0);
    check_log("neg5", 5, -1, 0);

    // Impulse with valid gaps; bubble data must not enter the taps.
    feed(4, 8'sd0);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0) ? 8'sd127 : 8'sd0, 1'b0, 2'd0, 8'sd0);
      step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 2'd0, 8'sd0);
    end
    check_log("gap0", 0, 16, 0);
    check_log("gap1", 1, 48, 0);
    check_log("gap2", 2, 48, 0);
    check_log("gap3", 3, 16, 0);
    check("gap_count", mlog_d.size(), 4);

    // Saturation with all coefficients at 127.
    for (int a = 0; a < 4; a++) step(1'b0, 8'sd0, 1'b1, 2'(a), 8'sd127);
    clear_log();
    feed(8, 8'sd127);
    check_log("satp", 7, 127, 1);
    feed(8, -8'sd128);
    check_log("satn", 15, -128, 1);
    do_reset("rst_sat_end");

    // Mid-stream reset: custom coef reverts, DC sequence restarts.
    step(1'b0, 8'sd0, 1'b1, 2'd1, 8'sd100);
    feed(4, 8'sd0);
    feed(3, 8'sd64);
    do_reset("rst_mid");
    clear_log();
    feed(6, 8'sd64);
    check_log("rdc0", 0, 8, 0);
    check_log("rdc1", 1, 32, 0);
    check_log("rdc2", 2, 56, 0);
    check_log("rdc3", 3, 64, 0);

    // Random traffic with occasional coefficient writes, some on valid edges.
    for (int i = 0; i < 400; i++) begin
      logic              v;
      logic signed [7:0] d;
      logic              we;
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'sd127 : -8'sd128)
                                       : 8'($urandom_range(0, 255));
      we = ($urandom_range(0, 7) == 0);
      step(v, d, we, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    // Drain so every queued expectation is compared.
    repeat (5) step(1'b0, 8'sd0, 1'b0, 2'd0, 8'sd0);
    @(negedge i_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
